// File: rtl/pattern_pkg.sv
// Shared definitions for the "101" pattern scan controller and its benches.
package pattern_pkg;

  typedef enum logic [2:0] {
    PRIME = 3'd0,
    IDLE  = 3'd1,
    SHIFT = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Two zero bits return the detector to Init from any of its states.
  localparam int FLUSH_LEN_DEF = 2;
  localparam logic [2:0] PATTERN = 3'b101;

endpackage

// File: rtl/pattern_scan_ctrl_if.sv
// Word request / result handshake bundle between a requester and pattern_scan_ctrl.
interface pattern_scan_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_word;
  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] hit_count;

  modport master (
    output in_valid, in_word, res_ready,
    input  in_ready, res_valid, hit_count
  );

  modport slave (
    input  in_valid, in_word, res_ready,
    output in_ready, res_valid, hit_count
  );
endinterface

// File: rtl/pattern_serializer.sv
// Parallel-load shift register that presents a word MSB-first, with a bit index
// so the controller knows the first and last shift cycles.
module pattern_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] word,
  output logic             msb,
  output logic             first,
  output logic             last
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] shreg;
  logic [IW-1:0]    idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      idx   <= '0;
    end else if (load) begin
      shreg <= word;
      idx   <= '0;
    end else if (shift) begin
      shreg <= shreg << 1;
      idx   <= idx + IW'(1);
    end
  end

  assign msb   = shreg[WIDTH-1];
  assign first = (idx == '0);
  assign last  = (idx == IW'(WIDTH - 1));

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Sequencer that feeds words serially into an external "101" detector and
// returns the per-word hit count over a result handshake.
module pattern_scan_ctrl
  import pattern_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int FLUSH_LEN = FLUSH_LEN_DEF,
  parameter int CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  pattern_scan_ctrl_if.slave  bus,
  output logic                det_bit,
  input  logic                det_hit,
  output logic                busy
);
  localparam int FW = $clog2(FLUSH_LEN + 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_LEN - 1);

  state_t           state;
  logic [FW-1:0]    flush_cnt;
  logic             res_valid_q;
  logic [CNT_W-1:0] hit_cnt_q;
  logic             ser_msb;
  logic             ser_first;
  logic             ser_last;

  pattern_serializer #(.WIDTH(WIDTH)) u_ser (
    .clk   (clk),
    .rst   (rst),
    .load  (state == IDLE && bus.in_valid),
    .shift (state == SHIFT),
    .word  (bus.in_word),
    .msb   (ser_msb),
    .first (ser_first),
    .last  (ser_last)
  );

  // det_hit lags det_bit by one cycle, so the first shift cycle still shows the
  // flushed history and the first flush cycle shows the word's final bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= PRIME;
      flush_cnt   <= '0;
      res_valid_q <= 1'b0;
      hit_cnt_q   <= '0;
    end else begin
      case (state)
        PRIME: begin
          if (flush_cnt == FLUSH_LAST) begin
            flush_cnt <= '0;
            state     <= IDLE;
          end else begin
            flush_cnt <= flush_cnt + FW'(1);
          end
        end
        IDLE: begin
          if (bus.in_valid) begin
            hit_cnt_q <= '0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (!ser_first && det_hit)
            hit_cnt_q <= hit_cnt_q + CNT_W'(1);
          if (ser_last) begin
            flush_cnt <= '0;
            state     <= FLUSH;
          end
        end
        FLUSH: begin
          if (flush_cnt == '0 && det_hit)
            hit_cnt_q <= hit_cnt_q + CNT_W'(1);
          if (flush_cnt == FLUSH_LAST) begin
            flush_cnt   <= '0;
            res_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            flush_cnt <= flush_cnt + FW'(1);
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= PRIME;
      endcase
    end
  end

  assign det_bit       = (state == SHIFT) ? ser_msb : 1'b0;
  assign bus.in_ready  = (state == IDLE);
  assign busy          = (state != IDLE);
  assign bus.res_valid = res_valid_q;
  assign bus.hit_count = hit_cnt_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Self-checking bench for pattern_scan_ctrl with a behavioural "101" detector attached.
module tb_pattern_scan_ctrl;
  import pattern_pkg::*;

  localparam int WIDTH = 8;
  localparam int FLEN  = 2;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic clk = 1'b0;
  logic rst;
  logic det_bit;
  logic det_hit;
  logic busy;
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  pattern_scan_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  pattern_scan_ctrl #(.WIDTH(WIDTH), .FLUSH_LEN(FLEN), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .det_bit (det_bit),
    .det_hit (det_hit),
    .busy    (busy)
  );

  // Detector stand-in: registered hit when the last three bits seen match the pattern.
  logic [1:0] dhist = 2'b00;
  logic       dhit  = 1'b0;
  always @(posedge clk) begin
    dhit  <= ({dhist, det_bit} == PATTERN);
    dhist <= {dhist[0], det_bit};
  end
  assign det_hit = dhit;

  function automatic int refHits(input logic [WIDTH-1:0] w);
    int c = 0;
    for (int i = WIDTH - 1; i >= 2; i--)
      if ({w[i], w[i-1], w[i-2]} == PATTERN) c++;
    return c;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] w, input int stall, input bit finishHs);
    bit                     got = 0;
    int                     n = 0;
    int                     rdyHigh = 0;
    int                     expHits;
    logic [WIDTH+FLEN-1:0]  seq = '0;
    logic [WIDTH+FLEN-1:0]  expSeq;
    expHits = refHits(w);
    expSeq  = {w, {FLEN{1'b0}}};
    bus.in_word  = w;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      if (bus.in_ready) got = 1;
      step();
    end
    bus.in_valid = 1'b0;
    checkOutput("accept", 32'(got), 32'd1);
    while (!bus.res_valid && n < 40) begin
      if (n < WIDTH + FLEN) seq = {seq[WIDTH+FLEN-2:0], det_bit};
      if (bus.in_ready || !busy) rdyHigh++;
      n++;
      step();
    end
    checkOutput("latency", 32'(n + 1), 32'(WIDTH + FLEN + 1));
    checkOutput("detbits", 32'(seq), 32'(expSeq));
    checkOutput("ready_during_scan", 32'(rdyHigh), 32'd0);
    checkOutput("hits", 32'(bus.hit_count), 32'(expHits));
    for (int s = 0; s < stall; s++) begin
      step();
      checkOutput("stall_valid", 32'(bus.res_valid), 32'd1);
      checkOutput("stall_hits", 32'(bus.hit_count), 32'(expHits));
      checkOutput("stall_ready", 32'(bus.in_ready), 32'd0);
    end
    if (finishHs) begin
      bus.res_ready = 1'b1;
      step();
      bus.res_ready = 1'b0;
      checkOutput("post_valid", 32'(bus.res_valid), 32'd0);
      checkOutput("post_ready", 32'(bus.in_ready), 32'd1);
      checkOutput("post_hits", 32'(bus.hit_count), 32'(expHits));
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rvHigh;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_word   = '0;
    bus.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_busy", 32'(busy), 32'd1);
    checkOutput("rst_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("rst_valid", 32'(bus.res_valid), 32'd0);
    checkOutput("rst_hits", 32'(bus.hit_count), 32'd0);
    checkOutput("rst_detbit", 32'(det_bit), 32'd0);
    step();
    checkOutput("prime2_detbit", 32'(det_bit), 32'd0);
    checkOutput("prime2_ready", 32'(bus.in_ready), 32'd0);
    step();
    checkOutput("idle_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_valid", 32'(bus.res_valid), 32'd0);

    applyStimulus(8'hAD, 0, 1'b1);
    applyStimulus(8'h55, 0, 1'b1);
    applyStimulus(8'hFF, 0, 1'b1);
    applyStimulus(8'h00, 0, 1'b1);
    applyStimulus(8'hAA, 0, 1'b1);

    // Result handshake and a new word arrive together: only the handshake completes.
    applyStimulus(8'h01, 0, 1'b0);
    bus.res_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_word   = 8'h40;
    step();
    bus.res_ready = 1'b0;
    checkOutput("simul_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("simul_busy", 32'(busy), 32'd0);
    checkOutput("simul_valid", 32'(bus.res_valid), 32'd0);
    applyStimulus(8'h40, 0, 1'b1);

    applyStimulus(8'hAD, 5, 1'b1);

    // Reset in the middle of a scan aborts it.
    bus.in_word  = 8'hAD;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("midrst_busy", 32'(busy), 32'd1);
    checkOutput("midrst_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("midrst_detbit", 32'(det_bit), 32'd0);
    step();
    checkOutput("midrst_prime2", 32'(bus.in_ready), 32'd0);
    step();
    checkOutput("midrst_idle", 32'(bus.in_ready), 32'd1);
    rvHigh = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.res_valid) rvHigh++;
      step();
    end
    checkOutput("midrst_no_result", 32'(rvHigh), 32'd0);
    applyStimulus(8'h05, 0, 1'b1);

    for (int k = 0; k < 20; k++) begin
      repeat ($urandom_range(0, 2)) step();
      applyStimulus(WIDTH'($urandom), int'($urandom_range(0, 3)), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
